// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers pixel coordinates, data-valid, line/field strobes and lock status
// from a received hsync/vsync pair. Optional macro VGA_RX_MEASURE_EN adds line_len/field_len.
module vga_sync_rx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 29,
  parameter int V_TOTAL     = 521,
  parameter int LOCK_FIELDS = 2
) (
  input  logic        clk_p,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        ve,
  output logic        newline,
  output logic        newfield,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [10:0] line_len,
  output logic [10:0] field_len
`endif
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_TMO   = 11'(2 * H_TOTAL);
  localparam logic [10:0] V_TMO   = 11'(2 * V_TOTAL);
  localparam logic [10:0] X_FIRST = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] X_LAST  = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [10:0] Y_FIRST = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] Y_LAST  = 11'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FIELDS);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  good_cnt_r;
  logic [3:0]  good_cnt_s;
  logic        hs_q;
  logic        hs_d;
  logic        vs_q;
  logic        vs_d;
  logic        vs_pend_r;
  logic [10:0] x_r;
  logic [10:0] y_r;
  logic [10:0] x_off_s;
  logic [10:0] y_off_s;
  logic        hfall_s;
  logic        vfall_s;
  logic        field_start_s;
  logic        err_s;
  logic        err_pulse_s;
  logic        sync_err_r;
  logic        lock_s;
  logic        in_x_s;
  logic        in_y_s;

  assign hfall_s       = hs_d & ~hs_q;
  assign vfall_s       = vs_d & ~vs_q;
  assign field_start_s = hfall_s & (vs_pend_r | vfall_s);
  assign err_s         = (hfall_s && (x_r != H_LAST)) ||
                         (field_start_s && (y_r != V_LAST)) ||
                         (x_r == H_TMO) || (y_r == V_TMO);

  // Input sampling stage plus previous-sample registers for edge detection.
  always_ff @(posedge clk_p) begin
    if (rst) begin
      hs_q <= 1'b1;
      hs_d <= 1'b1;
      vs_q <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_q <= hsync_in;
      hs_d <= hs_q;
      vs_q <= vsync_in;
      vs_d <= vs_q;
    end
  end

  // Position counters re-anchored on each hsync fall; a pending vsync fall marks the next line as row 0.
  always_ff @(posedge clk_p) begin
    if (rst) begin
      x_r       <= 11'd0;
      y_r       <= 11'd0;
      vs_pend_r <= 1'b0;
    end else if (hfall_s) begin
      x_r       <= 11'd0;
      vs_pend_r <= 1'b0;
      if (field_start_s) begin
        y_r <= 11'd0;
      end else if (y_r != CNT_MAX) begin
        y_r <= y_r + 11'd1;
      end else begin
        y_r <= y_r;
      end
    end else begin
      if (x_r != CNT_MAX) begin
        x_r <= x_r + 11'd1;
      end else begin
        x_r <= x_r;
      end
      if (vfall_s) begin
        vs_pend_r <= 1'b1;
      end else begin
        vs_pend_r <= vs_pend_r;
      end
    end
  end

  // Lock state, clean-field counter and registered error pulse.
  always_ff @(posedge clk_p) begin
    if (rst) begin
      state_r    <= SEARCH;
      good_cnt_r <= 4'd0;
      sync_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      good_cnt_r <= good_cnt_s;
      sync_err_r <= err_pulse_s;
    end
  end

  // Next state: errors count only outside SEARCH, and an error beats a coincident field start.
  always_comb begin
    state_s     = state_r;
    good_cnt_s  = good_cnt_r;
    err_pulse_s = 1'b0;
    case (state_r)
      SEARCH: begin
        if (field_start_s) begin
          state_s    = ACQUIRE;
          good_cnt_s = 4'd0;
        end else begin
          state_s = SEARCH;
        end
      end
      ACQUIRE: begin
        if (err_s) begin
          state_s     = SEARCH;
          err_pulse_s = 1'b1;
        end else if (field_start_s) begin
          if ((good_cnt_r + 4'd1) == LOCK_N) begin
            state_s = LOCKED;
          end else begin
            good_cnt_s = good_cnt_r + 4'd1;
          end
        end else begin
          state_s = ACQUIRE;
        end
      end
      LOCKED: begin
        if (err_s) begin
          state_s     = SEARCH;
          err_pulse_s = 1'b1;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s    = SEARCH;
        good_cnt_s = 4'd0;
      end
    endcase
  end

  assign lock_s   = (state_r == LOCKED);
  assign x_off_s  = x_r - X_FIRST;
  assign y_off_s  = y_r - Y_FIRST;
  assign in_x_s   = (x_r >= X_FIRST) && (x_r <= X_LAST);
  assign in_y_s   = (y_r >= Y_FIRST) && (y_r <= Y_LAST);

  assign locked   = lock_s;
  assign sync_err = sync_err_r;
  assign ve       = lock_s & in_x_s & in_y_s;
  assign x        = lock_s ? x_off_s[9:0] : 10'd0;
  assign y        = lock_s ? y_off_s[9:0] : 10'd0;
  assign newline  = lock_s & (x_r == 11'd0);
  assign newfield = lock_s & (x_r == 11'd0) & (y_r == 11'd0);

`ifdef VGA_RX_MEASURE_EN
  // Length capture runs whether or not the receiver is locked.
  always_ff @(posedge clk_p) begin
    if (rst) begin
      line_len  <= 11'd0;
      field_len <= 11'd0;
    end else begin
      if (hfall_s) begin
        line_len <= x_r + 11'd1;
      end
      if (field_start_s) begin
        field_len <= y_r + 11'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a reduced raster: a transmitter-side stream generator drives the
// syncs, and an event-level reference model predicts every output on every clock.
`timescale 1ns/1ps
module tb_vga_sync_rx;
  localparam int HA = 16, HS = 4, HB = 3, HT = 28;
  localparam int VA = 8, VS = 2, VB = 3, VT = 16, LF = 2;
  localparam int XS = HS + HB, YS = VS + VB;

  logic       clk_p = 1'b0;
  logic       rst;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       ve;
  logic       newline;
  logic       newfield;
  logic       locked;
  logic       sync_err;
`ifdef VGA_RX_MEASURE_EN
  logic [10:0] line_len;
  logic [10:0] field_len;
`endif

  always #5 clk_p = ~clk_p;

  vga_sync_rx #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT), .LOCK_FIELDS(LF)
  ) dut (
    .clk_p(clk_p), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .ve(ve), .newline(newline), .newfield(newfield),
    .locked(locked), .sync_err(sync_err)
`ifdef VGA_RX_MEASURE_EN
    , .line_len(line_len), .field_len(field_len)
`endif
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: clocks since the last recognised line start, lines since the last field
  // start, and lock progress as a count of clean fields (-1 while searching).
  int mx, my, clean;
  bit merr, pend_ls, pend_fs, vpend, last_hs, last_vs;

  int serr_cnt = 0;
  int ve_cnt = 0;
  int lock_rise = -1;
  int first_ve_x = -1;
  int first_ve_y = -1;
  bit prev_locked = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit err, hf, vf;
    if (rst) begin
      mx = 0; my = 0; clean = -1; merr = 1'b0;
      pend_ls = 1'b0; pend_fs = 1'b0; vpend = 1'b0;
      last_hs = 1'b1; last_vs = 1'b1;
    end else begin
      // a line start seen on the wire takes effect one clock after it is sampled
      err = (pend_ls && mx != HT - 1) || (pend_fs && my != VT - 1) ||
            (mx == 2 * HT) || (my == 2 * VT);
      merr = 1'b0;
      if (clean >= 0 && err) begin
        clean = -1;
        merr = 1'b1;
      end else if (pend_fs) begin
        clean = (clean < 0) ? 0 : clean + 1;
      end
      if (pend_ls) begin
        mx = 0;
        my = pend_fs ? 0 : ((my < 2047) ? my + 1 : 2047);
      end else begin
        mx = (mx < 2047) ? mx + 1 : 2047;
      end
      hf = last_hs && !hs;
      vf = last_vs && !vs;
      if (vf) vpend = 1'b1;
      pend_ls = hf;
      pend_fs = hf && vpend;
      if (hf) vpend = 1'b0;
      last_hs = hs;
      last_vs = vs;
    end
  endtask

  function automatic logic [31:0] expected();
    logic lk, ev;
    logic [9:0] ex, ey;
    lk = (clean >= LF);
    ev = lk && mx >= XS && mx <= XS + HA - 1 && my >= YS && my <= YS + VA - 1;
    ex = lk ? 10'((mx - XS) & 1023) : 10'd0;
    ey = lk ? 10'((my - YS) & 1023) : 10'd0;
    return 32'({lk, merr, ev, lk && mx == 0, lk && mx == 0 && my == 0, ex, ey});
  endfunction

  task automatic tick(input bit hs, input bit vs);
    hsync_in = hs;
    vsync_in = vs;
    @(posedge clk_p);
    cyc++;
    model_step(hs, vs);
    @(negedge clk_p);
    check($sformatf("cyc%0d", cyc), 32'({locked, sync_err, ve, newline, newfield, x, y}), expected());
    serr_cnt += int'(sync_err);
    ve_cnt += int'(ve);
    if (locked && !prev_locked) lock_rise = cyc;
    prev_locked = locked;
    if (ve && first_ve_x < 0) begin
      first_ve_x = int'(x);
      first_ve_y = int'(y);
    end
  endtask

  task automatic send_seg(input int from, input int upto, input bit vs_low, input bit hs_ok);
    for (int i = from; i < upto; i++) tick(hs_ok ? (i >= HS) : 1'b1, !vs_low);
  endtask

  task automatic send_field(input int bad_line, input int bad_len, output int start_idx);
    start_idx = cyc + 1;
    for (int v = 0; v < VT; v++) send_seg(0, (v == bad_line) ? bad_len : HT, v < VS, 1'b1);
  endtask

  initial begin
    int fs, b, n, k, serr0;
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    rst = 1'b0;
    repeat (5) tick(1'b1, 1'b1);
    check("reset_idle", 32'({locked, sync_err, ve, newline, newfield, x, y}), 32'd0);

    // clean stream: lock on the third field start, then one fully locked field
    send_field(-1, 0, fs);
    send_field(-1, 0, fs);
    send_field(-1, 0, fs);
    check("lock_rise", 32'(lock_rise), 32'(fs + 1));
    check("first_ve_x", 32'(first_ve_x), 32'd0);
    check("first_ve_y", 32'(first_ve_y), 32'd0);
    ve_cnt = 0;
    send_field(-1, 0, fs);
    check("ve_per_field", 32'(ve_cnt), 32'(HA * VA));
    check("locked_steady", 32'(locked), 32'd1);

    // one line a clock short, then relock after three further field starts
    serr0 = serr_cnt;
    b = int'($urandom_range(VT - 2, 0));
    send_field(b, HT - 1, fs);
    check("short_line_err", 32'(serr_cnt - serr0), 32'd1);
    check("short_line_unlock", 32'(locked), 32'd0);
    repeat (3) send_field(-1, 0, fs);
    check("short_line_relock", 32'(lock_rise), 32'(fs + 1));

    // hsync stuck high part way through a field
    serr0 = serr_cnt;
    n = int'($urandom_range(VT - 2, 1));
    for (int v = 0; v < n; v++) send_seg(0, HT, v < VS, 1'b1);
    send_seg(0, 2 * HT + 10 + int'($urandom_range(20, 0)), 1'b0, 1'b0);
    check("stuck_err", 32'(serr_cnt - serr0), 32'd1);
    check("stuck_outputs", 32'({locked, ve, newline, newfield, x, y}), 32'd0);
    repeat (3) send_field(-1, 0, fs);
    check("stuck_relock", 32'(lock_rise), 32'(fs + 1));

    // reset pulse mid-field while locked
    send_field(-1, 0, fs);
    serr0 = serr_cnt;
    n = int'($urandom_range(VT - 1, VS));
    k = int'($urandom_range(HT - 2, 0));
    for (int v = 0; v < n; v++) send_seg(0, HT, v < VS, 1'b1);
    send_seg(0, k, 1'b0, 1'b1);
    rst = 1'b1;
    send_seg(k, k + 1, 1'b0, 1'b1);
    rst = 1'b0;
    check("rst_outputs", 32'({locked, sync_err, ve, newline, newfield, x, y}), 32'd0);
    send_seg(k + 1, HT, 1'b0, 1'b1);
    for (int v = n + 1; v < VT; v++) send_seg(0, HT, 1'b0, 1'b1);
    repeat (3) send_field(-1, 0, fs);
    check("rst_no_err", 32'(serr_cnt - serr0), 32'd0);
    check("rst_relock", 32'(lock_rise), 32'(fs + 1));

    // random line-length jitter, checked cycle by cycle against the model
    repeat (4) begin
      for (int v = 0; v < VT; v++) begin
        b = int'($urandom_range(7, 0));
        send_seg(0, (b == 0) ? HT - 1 : ((b == 1) ? HT + 1 : HT), v < VS, 1'b1);
      end
    end

`ifdef VGA_RX_MEASURE_EN
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    lock_rise = -1;
    serr0 = serr_cnt;
    repeat (3) begin
      for (int v = 0; v < VT + 1; v++) send_seg(0, HT + 2, v < VS, 1'b1);
    end
    check("line_len", 32'(line_len), 32'(HT + 2));
    check("field_len", 32'(field_len), 32'(VT + 1));
    check("measure_never_locked", 32'(lock_rise), 32'hffffffff);
    check("measure_err_per_attempt", 32'(serr_cnt - serr0), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Sync-stream receiver for the VGA timing path: samples an incoming hsync/vsync pair generated in the pixel-clock domain, recovers pixel coordinates, data-valid, line/field strobes and a lock indication. It is the capture-side counterpart of the VGA timing generator. It sits behind a video input port and feeds frame-capture or overlay logic that needs coordinates of the received stream.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hsync low width (clocks)
- H_BACK, 48, back porch (clocks)
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines per field
- V_SYNC, 2, vsync low width (lines)
- V_BACK, 29, back porch (lines)
- V_TOTAL, 521, lines per field
- LOCK_FIELDS, 2, consecutive clean fields required to lock (1..15)

- clk_p  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- hsync_in  in  1  received hsync, active low, synchronous to clk_p
- vsync_in  in  1  received vsync, active low, synchronous to clk_p
- x  out  10  recovered column, 0 at first visible pixel
- y  out  10  recovered row, 0 at first visible line
- ve  out  1  visible-pixel valid
- newline  out  1  one-clock pulse at line start
- newfield  out  1  one-clock pulse at field start
- locked  out  1  stream matches configured timing
- sync_err  out  1  one-clock pulse on timing violation

## Operation
- Stage 1: hs_q/vs_q register inputs; hs_d/vs_d hold previous hs_q/vs_q.
- hfall = hs_d & ~hs_q; vfall = vs_d & ~vs_q.
- vs_pend set on vfall, cleared when consumed at hfall (vfall on the hfall cycle counts).
- x_r (11 b): 0 on hfall, else x_r+1 saturating at 2047.
- y_r (11 b), updated only on hfall: 0 if vs_pend|vfall, else y_r+1 saturating at 2047.
- Line check at hfall: error if x_r != H_TOTAL-1 (first hfall after SEARCH exempt).
- Field check at field start: error if y_r != V_TOTAL-1.
- Timeout error: x_r reaches 2*H_TOTAL, or y_r reaches 2*V_TOTAL.
- FSM SEARCH -> ACQUIRE on first field start; good_cnt=0.
- ACQUIRE: each clean field start increments good_cnt; reaching LOCK_FIELDS -> LOCKED.
- Any error in ACQUIRE or LOCKED -> SEARCH with a sync_err pulse; errors in SEARCH ignored.
- Error and field start on the same cycle: error wins.
- Gated outputs, all 0 unless LOCKED:
  - ve = x_r in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and y_r in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
  - x = (x_r - H_SYNC - H_BACK)[9:0]; y = (y_r - V_SYNC - V_BACK)[9:0] (mod-1024 wrap outside visible area).
  - newline = (x_r==0); newfield = (x_r==0 && y_r==0).

## Timing
- Reset: all registers 0, FSM SEARCH, hs_q/hs_d/vs_q/vs_d = 1; outputs 0 the clock after rst sampled high.
- Latency: x_r/y_r equal the transmitter's internal counters delayed by exactly 2 clk_p.
- x, y, ve, newline and newfield are combinational from registered state and carry the same 2-clock lag.
- locked rises on the clock after the field start that completes LOCK_FIELDS.
- locked falls, and sync_err pulses, on the clock after the offending hfall or timeout.
- rst mid-field: immediate return to SEARCH; no sync_err.

## Configuration
- VGA_RX_MEASURE_EN defined:
  - adds outputs line_len[10:0] = x_r+1, captured at every hfall;
  - adds field_len[10:0] = y_r+1, captured at every field start;
  - both reset to 0 and update regardless of lock.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

## Test plan
- Reset with syncs idle high for 5 clocks -> locked=0, x=0, y=0, ve=0, newline=0, sync_err=0.
- Clean 800x521 stream, LOCK_FIELDS=2 -> locked=1 two clocks after the third vsync fall; first ve=1 with x=0, y=0 at transmitter counters (144,31)+2 clocks; exactly 640x480 ve cycles per locked field.
- One 799-clock line while locked -> sync_err pulse and locked=0 two clocks after that hsync fall; relock after three further clean vsync falls.
- hsync stuck high while locked -> sync_err when x_r reaches 1600; outputs zero; relock on restored stream.
- rst pulsed mid-field while locked -> all outputs 0 next clock, no sync_err; relock after three vsync falls.
- With VGA_RX_MEASURE_EN, stream of 858-clock lines x 525 lines -> line_len=858, field_len=525, locked stays 0, sync_err pulses once per ACQUIRE attempt.
